fn_result_pipe: RTL
===================

Name: fn_result_pipe

Overview:
Registered, handshaked successor to the ALU function-class result select.
- Selects one of NUM_FN function-unit results by function class and latches it into an output register.
- Supports multi-cycle units (e.g. multiply/divide) that signal completion with a done strobe, then presents the result to writeback under valid/ready backpressure.
- Sits between the execute-stage function units and the register-file writeback port.

Parameters:
WIDTH, 32, datapath width of every function-unit result and of result
NUM_FN, 8, number of function-class inputs; classes >= NUM_FN select constant zero
SEL_W, 3, width of fn_class; must satisfy 2**SEL_W >= NUM_FN
MULTI_MASK, 8'b0000_0000, bit i set = class i is multi-cycle and waits for fn_done[i]

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; drops any pending or held result
issue_valid  input  1  an instruction's function class is being issued
issue_ready  output  1  block can accept an issue this cycle
fn_class  input  SEL_W  function class of the issued operation
fn_data  input  NUM_FN*WIDTH  concatenated unit results; class i occupies bits [i*WIDTH +: WIDTH]
fn_done  input  NUM_FN  per-class completion strobe; only meaningful for multi-cycle classes
result  output  WIDTH  registered selected result
result_class  output  SEL_W  class that produced result
result_valid  output  1  result holds valid data
result_ready  input  1  writeback accepts result
busy  output  1  high in WAIT state

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - result=0, result_class=0, result_valid=0, busy=0, pending class register=0.
- States:
  - IDLE: no result held.
  - WAIT: multi-cycle op pending; class held internally.
  - HOLD: result_valid=1.
- issue_ready = (state==IDLE) | (state==HOLD & result_ready). It is 0 in WAIT.
- Issue fires when issue_valid & issue_ready.
- Single-cycle class (MULTI_MASK bit clear, or class >= NUM_FN):
  - fn_data slice is captured on the issue edge.
  - Next state is HOLD, so result_valid rises one cycle after issue (latency 1).
  - Class >= NUM_FN captures 0.
- Multi-cycle class:
  - Issue edge stores the class; next state is WAIT, busy=1.
  - In WAIT, fn_done[pending] high captures the matching fn_data slice; next state is HOLD.
  - fn_done on other bits is ignored.
  - fn_done asserted in the same cycle as the issue is ignored; the unit must assert done at least one cycle after issue.
- HOLD:
  - result, result_class and result_valid are stable until result_ready.
  - result_ready without a simultaneous issue: next state is IDLE, result_valid=0; result keeps its last value.
  - result_ready with a simultaneous issue (back-to-back): the completing transfer and the new issue happen on the same edge, with no bubble for single-cycle classes.
- flush:
  - Forces IDLE and result_valid=0 next edge from any state.
  - Overrides issue, fn_done and result_ready in the same cycle.
  - issue_ready is still computed normally, but an issue accepted in a flush cycle is dropped.
- Reset mid-operation (WAIT or HOLD): immediately returns to reset values; the pending operation is lost.
- No FIFO: capacity is exactly one result.

Decomposition:
- Shared package fn_pkg:
  - SEL_W/NUM_FN defaults.
  - FnClass localparams (FN_LUI=0, FN_SLT=1, FN_SGT=2, FN_ARITH=3, FN_LOGIC=4, FN_SHIFT=5, FN_HAM=6, FN_NONE=7).
  - State encoding (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2).
- One sub-module, fn_slice_sel: purely combinational indexed slice select with out-of-range-to-zero. The FSM and registers stay in fn_result_pipe.

Test Plan:
- Config: defaults with MULTI_MASK=8'b0000_1000 (class 3 multi-cycle).
- Single-cycle: issue class 5 with slice 5 = 32'hDEAD_BEEF, result_ready=1 -> next cycle result=DEADBEEF, result_class=5, result_valid=1 for exactly one cycle.
- Multi-cycle: issue class 3, fn_done[3] asserted 4 cycles later with slice 3 = 32'h0000_1234 -> busy=1 and issue_ready=0 for those cycles; result_valid one cycle after done, result=0x1234. Asserting fn_done[2] during WAIT has no effect.
- Backpressure: result_ready=0 for 5 cycles after a class-1 result (32'h1) while fn_data changes -> result stays 1 and issue_ready=0. Raising result_ready with a class-6 issue (slice=32'h10) -> next cycle result=0x10, no bubble.
- Out-of-range: NUM_FN=6, issue class 7 -> result=0, result_class=7, result_valid=1.
- Flush/reset: flush in WAIT -> next cycle IDLE, busy=0, and a later fn_done[3] produces no result. Pull rst_n low mid-HOLD -> result_valid and result drop to 0 without a clock edge.

Source files
------------

// File: rtl/fn_pkg.sv
// Shared definitions for the function-class result pipeline: default
// sizing, function-class identifiers and the FSM state encoding.
package fn_pkg;

  // Default sizing of the function-class select.
  localparam int FN_SEL_W_DEF = 3;
  localparam int FN_NUM_DEF   = 8;
  localparam int FN_WIDTH_DEF = 32;

  // Function-class identifiers as driven on fn_class by the decoder.
  localparam logic [FN_SEL_W_DEF-1:0] FN_LUI   = 3'd0;
  localparam logic [FN_SEL_W_DEF-1:0] FN_SLT   = 3'd1;
  localparam logic [FN_SEL_W_DEF-1:0] FN_SGT   = 3'd2;
  localparam logic [FN_SEL_W_DEF-1:0] FN_ARITH = 3'd3;
  localparam logic [FN_SEL_W_DEF-1:0] FN_LOGIC = 3'd4;
  localparam logic [FN_SEL_W_DEF-1:0] FN_SHIFT = 3'd5;
  localparam logic [FN_SEL_W_DEF-1:0] FN_HAM   = 3'd6;
  localparam logic [FN_SEL_W_DEF-1:0] FN_NONE  = 3'd7;

  // Result pipeline FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fn_state_e;

endpackage

// File: rtl/fn_slice_sel.sv
// Combinational indexed slice select: returns slice sel of the packed
// data bus, or zero when sel names a class that does not exist.
module fn_slice_sel
  import fn_pkg::*;
#(
  parameter int WIDTH  = FN_WIDTH_DEF,
  parameter int NUM_FN = FN_NUM_DEF,
  parameter int SEL_W  = FN_SEL_W_DEF
) (
  input  logic [NUM_FN*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out
);

  // Compare against every legal index; anything unmatched stays zero.
  always_comb begin
    out = '0;
    for (int i = 0; i < NUM_FN; i++) begin
      if (sel == SEL_W'(i)) begin
        out = data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/fn_result_pipe.sv
// Registered, handshaked function-class result select. Captures one
// function-unit result (immediately, or after a done strobe for
// multi-cycle units) and holds it for writeback under valid/ready.
module fn_result_pipe
  import fn_pkg::*;
#(
  parameter int               WIDTH      = FN_WIDTH_DEF,
  parameter int               NUM_FN     = FN_NUM_DEF,
  parameter int               SEL_W      = FN_SEL_W_DEF,
  parameter logic [NUM_FN-1:0] MULTI_MASK = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [SEL_W-1:0]        fn_class,
  input  logic [NUM_FN*WIDTH-1:0] fn_data,
  input  logic [NUM_FN-1:0]       fn_done,
  output logic [WIDTH-1:0]        result,
  output logic [SEL_W-1:0]        result_class,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy
);

  fn_state_e          state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SEL_W-1:0]   class_q, class_d;
  logic [SEL_W-1:0]   pending_q, pending_d;

  logic [SEL_W-1:0]   sel_idx;
  logic [WIDTH-1:0]   sel_data;
  logic               issue_multi;
  logic               done_hit;

  // While waiting, the selector looks at the pending class; otherwise at
  // the class being issued.
  always_comb begin
    sel_idx = (state_q == ST_WAIT) ? pending_q : fn_class;
  end

  fn_slice_sel #(
    .WIDTH  (WIDTH),
    .NUM_FN (NUM_FN),
    .SEL_W  (SEL_W)
  ) u_slice_sel (
    .data (fn_data),
    .sel  (sel_idx),
    .out  (sel_data)
  );

  // Classify the issued class and detect completion of the pending unit;
  // out-of-range classes never match and therefore count as single-cycle.
  always_comb begin
    issue_multi = 1'b0;
    done_hit    = 1'b0;
    for (int i = 0; i < NUM_FN; i++) begin
      if (fn_class == SEL_W'(i)) begin
        issue_multi = MULTI_MASK[i];
      end
      if (pending_q == SEL_W'(i)) begin
        done_hit = fn_done[i];
      end
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    issue_ready  = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & result_ready);
    result_valid = (state_q == ST_HOLD);
    busy         = (state_q == ST_WAIT);
    result       = result_q;
    result_class = class_q;
  end

  // Next-state and capture logic; flush wins over every other event.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    class_d   = class_q;
    pending_d = pending_q;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (issue_valid) begin
            if (issue_multi) begin
              pending_d = fn_class;
              state_d   = ST_WAIT;
            end else begin
              result_d = sel_data;
              class_d  = fn_class;
              state_d  = ST_HOLD;
            end
          end
        end
        ST_WAIT: begin
          if (done_hit) begin
            result_d = sel_data;
            class_d  = pending_q;
            state_d  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (result_ready) begin
            // Current result drains this edge; a concurrent issue takes
            // its place with no idle cycle in between.
            if (issue_valid) begin
              if (issue_multi) begin
                pending_d = fn_class;
                state_d   = ST_WAIT;
              end else begin
                result_d = sel_data;
                class_d  = fn_class;
                state_d  = ST_HOLD;
              end
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      class_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      class_q   <= class_d;
      pending_q <= pending_d;
    end
  end

endmodule
